deserializer: RTL
=================

Name: deserializer

Overview:
- Receive-side counterpart of the serializer: accepts one BIT_WIDTH-bit sample per val/rdy handshake and assembles N_SAMPLES consecutive samples into one wide parallel word.
- Presents the assembled word on a val/rdy output interface.
- Sits between the serial sample stream and parallel consumers (e.g. FFT input).
- Holds one frame; stalls the input while a completed frame awaits consumption.

Parameters:
- BIT_WIDTH, 32, width of each sample.
- N_SAMPLES, 8, samples per frame; legal values are 2 or greater. Counter width is $clog2(N_SAMPLES).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- recv_msg  input  BIT_WIDTH  incoming sample.
- recv_val  input  1  upstream asserts when recv_msg is valid.
- recv_rdy  output  1  block can accept a sample this cycle.
- send_msg  output  BIT_WIDTH*N_SAMPLES  assembled frame; sample k occupies bits [(k+1)*BIT_WIDTH-1 : k*BIT_WIDTH].
- send_val  output  1  frame in send_msg is complete.
- send_rdy  input  1  downstream can take the frame.

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - state = COLLECT, count = 0, all N_SAMPLES slot registers = 0.
  - send_val = 0 and recv_rdy = 0 during any cycle in which reset is high.
  - Reset has priority over every handshake, including mid-frame and in DONE. A partial or unsent frame is discarded.
- Handshakes: a transfer occurs on a rising edge where val && rdy. recv_rdy and send_val depend only on registered state and reset, never on recv_val or send_rdy (no combinational val-to-rdy path).
- COLLECT state:
  - recv_rdy = 1, send_val = 0.
  - On recv transfer: slot[count] <= recv_msg.
  - If count == N_SAMPLES-1: count <= 0 and state <= DONE. Otherwise count <= count+1.
  - recv_val low: no change.
- DONE state:
  - recv_rdy = 0, send_val = 1.
  - send_msg is stable for as long as send_val is high (backpressure of any length).
  - On send transfer: state <= COLLECT. Slots are not cleared; they are overwritten by the next frame.
- Throughput and latency:
  - send_val rises the cycle after the Nth sample is accepted.
  - Earliest restart of collection is the cycle after the send transfer.
  - Back-to-back frames with send_rdy held high take N_SAMPLES+1 cycles per frame.
- send_msg is always the concatenation of slot registers.
  - Contents are valid only when send_val = 1.
  - During COLLECT, partially updated slots are visible; consumers ignore them.
- Gaps: recv_val deasserted mid-frame pauses collection indefinitely; count and slots are held.
- No bypass: a sample offered while in DONE is not accepted (recv_rdy = 0). Upstream holds it.
- Unreachable: a count value of N_SAMPLES or above is not reachable; no recovery logic is required.

Test Plan:
- Basic frame (BIT_WIDTH=32, N_SAMPLES=8):
  - Assert reset 2 cycles and check recv_rdy=0, send_val=0, send_msg=0.
  - Release reset, then send samples 1..8 on consecutive cycles with send_rdy=1.
  - Required: send_val=1 exactly one cycle after sample 8 is accepted; send_msg slot k = k+1; recv_rdy=0 that cycle and 1 the next.
- Backpressure:
  - Complete a frame with samples 0xA0..0xA7, hold send_rdy=0 for 10 cycles while recv_val=1 with 0xFF.
  - Required: send_val held at 1, send_msg unchanged, recv_rdy=0 throughout, no 0xFF in any slot.
  - Raise send_rdy and check the next accepted sample lands in slot 0.
- Input gaps:
  - Send 8 samples with random recv_val bubbles (about 50% duty).
  - Required: frame identical to the gap-free case; send_val rises one cycle after the 8th accepted sample.
- Streaming: send 4 consecutive frames with send_rdy=1 and recv_val=1 whenever recv_rdy=1.
  - Required: each frame matches a scoreboard.
  - Required: 9-cycle frame period.
- Reset mid-operation:
  - Case A: assert reset after 5 of 8 samples. Required: next frame starts at slot 0; old slots read 0 until overwritten.
  - Case B: assert reset while in DONE with send_rdy=0. Required: send_val=0 the cycle reset is high; frame is never delivered.
- Minimum size (N_SAMPLES=2, BIT_WIDTH=8):
  - Send 0x11, 0x22.
  - Required: send_msg = 0x2211, send_val high on the following cycle.

Source files
------------

// File: rtl/deserializer.sv
// Sample-to-frame deserializer: gathers N_SAMPLES val/rdy samples into one wide
// word and holds it on a val/rdy output until the consumer takes it.
module deserializer #(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [BIT_WIDTH-1:0]           recv_msg,
    input  logic                           recv_val,
    output logic                           recv_rdy,
    output logic [BIT_WIDTH*N_SAMPLES-1:0] send_msg,
    output logic                           send_val,
    input  logic                           send_rdy
);
    localparam int             CW   = $clog2(N_SAMPLES);
    localparam logic [CW-1:0]  LAST = CW'(N_SAMPLES - 1);

    typedef enum logic {COLLECT, DONE} state_t;

    state_t                                r_state;
    logic [CW-1:0]                         r_count;
    logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]   r_slot;
    logic                                  w_recv_xfer;
    logic                                  w_send_xfer;

    // Handshake outputs come only from state and reset, so no val-to-rdy path exists.
    assign recv_rdy    = !reset && (r_state == COLLECT);
    assign send_val    = !reset && (r_state == DONE);
    assign w_recv_xfer = recv_val && recv_rdy;
    assign w_send_xfer = send_val && send_rdy;
    assign send_msg    = r_slot;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= COLLECT;
            r_count <= '0;
            r_slot  <= '0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_recv_xfer) begin
                        r_slot[r_count] <= recv_msg;
                        if (r_count == LAST) begin
                            r_count <= '0;
                            r_state <= DONE;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Slots are left as-is; the next frame overwrites them.
                    if (w_send_xfer) r_state <= COLLECT;
                end
                default: r_state <= COLLECT;
            endcase
        end
    end
endmodule
